// File: rtl/fp_add_pkg.sv
// Shared definitions for the adder-sharing slice of the single-precision FP adder:
// sequencing FSM encoding and the width of the shared integer adder.
package fp_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int ADD_W = 32;
    localparam int SUM_W = 33;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr with wrap-around
// and grants the first asserted request, as one-hot and as a binary index.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    // Rotating priority search; the found flag keeps only the first hit.
    always_comb begin
        int  idx;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/thirtyTwoBitAdder.sv
// 32-bit carry-lookahead adder: eight 4-bit lookahead groups whose group
// generate/propagate terms feed a second-level carry chain. 33-bit result,
// bit 32 is the carry out.
module thirtyTwoBitAdder (
    input  logic [31:0] inputA,
    input  logic [31:0] inputB,
    output logic [32:0] sum
);

    logic [31:0] gen;
    logic [31:0] prop;
    logic [7:0]  grpG;
    logic [7:0]  grpP;
    logic [8:0]  grpC;
    logic [32:0] carry;

    assign gen  = inputA & inputB;
    assign prop = inputA ^ inputB;

    // Group terms, group carries and per-bit carries, all derived from bit g/p.
    always_comb begin
        grpG  = '0;
        grpP  = '0;
        grpC  = '0;
        carry = '0;
        for (int k = 0; k < 8; k++) begin
            grpP[k] = &prop[4*k +: 4];
            grpG[k] = gen[4*k+3]
                    | (prop[4*k+3] & gen[4*k+2])
                    | (prop[4*k+3] & prop[4*k+2] & gen[4*k+1])
                    | (prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & gen[4*k]);
        end
        grpC[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            grpC[k+1] = grpG[k] | (grpP[k] & grpC[k]);
        end
        for (int k = 0; k < 8; k++) begin
            carry[4*k]   = grpC[k];
            carry[4*k+1] = gen[4*k] | (prop[4*k] & grpC[k]);
            carry[4*k+2] = gen[4*k+1]
                         | (prop[4*k+1] & gen[4*k])
                         | (prop[4*k+1] & prop[4*k] & grpC[k]);
            carry[4*k+3] = gen[4*k+2]
                         | (prop[4*k+2] & gen[4*k+1])
                         | (prop[4*k+2] & prop[4*k+1] & gen[4*k])
                         | (prop[4*k+2] & prop[4*k+1] & prop[4*k] & grpC[k]);
        end
        carry[32] = grpC[8];
    end

    assign sum = {carry[32], prop ^ carry[31:0]};

endmodule

// File: rtl/fp_adder_share_arb.sv
// Shares one 32-bit adder between NUM_REQ datapath units. One transaction in
// flight: grant and capture operands (IDLE), let the adder settle a full cycle
// (ADD), then hold the tagged result until the consumer takes it (RESP).
import fp_add_pkg::*;

module fp_adder_share_arb #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*32-1:0]   req_a,
    input  logic [NUM_REQ*32-1:0]   req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [32:0]             rsp_sum,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    busy,
    output logic [CNT_W-1:0]        ops_done
);

    state_t             r_state;
    state_t             w_next_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_id_q;
    logic [ADD_W-1:0]   r_op_a;
    logic [ADD_W-1:0]   r_op_b;
    logic [SUM_W-1:0]   r_rsp_sum;
    logic [ID_W-1:0]    r_rsp_id;
    logic               r_rsp_valid;
    logic [CNT_W-1:0]   r_ops_done;

    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_gnt_idx;
    logic [ID_W-1:0]    w_ptr_next;
    logic [ADD_W-1:0]   w_sel_a;
    logic [ADD_W-1:0]   w_sel_b;
    logic [SUM_W-1:0]   w_add_sum;
    logic               w_accept;
    logic               w_handshake;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (r_rr_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    // The adder only ever sees the captured operands, never the live request bus.
    thirtyTwoBitAdder u_adder (
        .inputA (r_op_a),
        .inputB (r_op_b),
        .sum    (w_add_sum)
    );

    assign w_accept    = (r_state == IDLE) && (|req_valid);
    assign w_handshake = (r_state == RESP) && rsp_ready;

    // Select the winner's operand slices and the pointer position just past it.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_idx == ID_W'(i)) begin
                w_sel_a = req_a[32*i +: 32];
                w_sel_b = req_b[32*i +: 32];
            end
        end
        if (w_gnt_idx == ID_W'(NUM_REQ - 1)) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = w_gnt_idx + ID_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state: fixed two-cycle issue, then wait for the response handshake.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept)    w_next_state = ADD;
            ADD:                      w_next_state = RESP;
            RESP:    if (w_handshake) w_next_state = IDLE;
            default:                  w_next_state = IDLE;
        endcase
    end

    // FSM outputs: grants only while idle and out of reset, busy otherwise.
    always_comb begin
        req_ready = '0;
        busy      = (r_state != IDLE);
        if ((r_state == IDLE) && rst_n) begin
            req_ready = w_gnt;
        end
    end

    // Operand capture, result registering, round-robin pointer and completion count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_id_q      <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_rsp_sum   <= '0;
            r_rsp_id    <= '0;
            r_rsp_valid <= 1'b0;
            r_ops_done  <= '0;
        end else begin
            if (w_accept) begin
                r_op_a   <= w_sel_a;
                r_op_b   <= w_sel_b;
                r_id_q   <= w_gnt_idx;
                r_rr_ptr <= w_ptr_next;
            end
            if (r_state == ADD) begin
                r_rsp_sum   <= w_add_sum;
                r_rsp_id    <= r_id_q;
                r_rsp_valid <= 1'b1;
            end
            if (w_handshake) begin
                r_rsp_valid <= 1'b0;
                r_ops_done  <= r_ops_done + CNT_W'(1);
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_id    = r_rsp_id;
    assign ops_done  = r_ops_done;

endmodule
